// File: rtl/shift_reg_seq.sv
// Parametrised universal shift register with a multi-cycle shift-by-N sequencer.
// Optional feature: define USHIFT_ROTATE_EN to enable rotate (op 111, wrapping shrN/shlN).
module shift_reg_seq #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              AMT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR1 = 3'b001;
    localparam logic [2:0] OP_SHL1 = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ASR1 = 3'b100;
    localparam logic [2:0] OP_SHRN = 3'b101;
    localparam logic [2:0] OP_SHLN = 3'b110;
    localparam logic [2:0] OP_ROTR = 3'b111;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic             so_q;
    logic             done_q;
    logic             left_q;
    logic [AMT_W-1:0] cnt_q;

    logic [AMT_W-1:0] amt_clamped;
    logic             seq_shr_fill;
    logic             seq_shl_fill;

    assign amt_clamped = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;

    // Fill bits used by the sequencer: wrap the outgoing bit when rotating, else si.
`ifdef USHIFT_ROTATE_EN
    assign seq_shr_fill = q_q[0];
    assign seq_shl_fill = q_q[WIDTH-1];
`else
    assign seq_shr_fill = si;
    assign seq_shl_fill = si;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= RESET_VAL;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
            left_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    case (op)
                        OP_SHR1: begin
                            q_q  <= {si, q_q[WIDTH-1:1]};
                            so_q <= q_q[0];
                        end
                        OP_SHL1: begin
                            q_q  <= {q_q[WIDTH-2:0], si};
                            so_q <= q_q[WIDTH-1];
                        end
                        OP_LOAD: q_q <= d;
                        OP_ASR1: begin
                            q_q  <= {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                            so_q <= q_q[0];
                        end
                        OP_SHRN, OP_SHLN: begin
                            state_q <= SHIFT;
                            cnt_q   <= amt_clamped;
                            left_q  <= (op == OP_SHLN);
                        end
`ifdef USHIFT_ROTATE_EN
                        OP_ROTR: begin
                            q_q  <= {q_q[0], q_q[WIDTH-1:1]};
                            so_q <= q_q[0];
                        end
`endif
                        default: ;
                    endcase
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        if (left_q) begin
                            q_q  <= {q_q[WIDTH-2:0], seq_shl_fill};
                            so_q <= q_q[WIDTH-1];
                        end else begin
                            q_q  <= {seq_shr_fill, q_q[WIDTH-1:1]};
                            so_q <= q_q[0];
                        end
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign q    = q_q;
    assign so   = so_q;
    assign busy = (state_q == SHIFT);
    assign done = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed self-checking bench for shift_reg_seq (WIDTH=8, RESET_VAL=0).
module tb_shift_reg_seq;

`ifdef USHIFT_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] op;
    logic [7:0] d;
    logic       si;
    logic [3:0] amt;
    logic [7:0] q;
    logic       so;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    shift_reg_seq #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk  (clk),
        .rst  (rst),
        .op   (op),
        .d    (d),
        .si   (si),
        .amt  (amt),
        .q    (q),
        .so   (so),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] d;
        logic       si;
        logic [7:0] exp_q;
        logic       exp_so;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [7:0] eq, input logic eb, input logic ed);
        check({name, ".q"}, 32'(q), 32'(eq));
        check({name, ".busy"}, 32'(busy), 32'(eb));
        check({name, ".done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        vecs[0] = '{3'b011, 8'h81, 1'b0, 8'h81, 1'b0};
        vecs[1] = '{3'b010, 8'h00, 1'b1, 8'h03, 1'b1};
        vecs[2] = '{3'b001, 8'h00, 1'b0, 8'h01, 1'b1};
        vecs[3] = '{3'b011, 8'h80, 1'b0, 8'h80, 1'b1};
        vecs[4] = '{3'b100, 8'h00, 1'b1, 8'hC0, 1'b0};
        vecs[5] = '{3'b100, 8'h00, 1'b0, 8'hE0, 1'b0};
        vecs[6] = '{3'b000, 8'h55, 1'b1, 8'hE0, 1'b0};
        vecs[7] = '{3'b011, 8'h81, 1'b0, 8'h81, 1'b0};
        vecs[8] = '{3'b111, 8'h00, 1'b0, ROT ? 8'hC0 : 8'h81, ROT ? 1'b1 : 1'b0};

        rst = 1'b1; op = 3'b000; d = 8'h00; si = 1'b0; amt = 4'd0;
        #12;
        check_state("reset", 8'h00, 1'b0, 1'b0);
        check("reset.so", 32'(so), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            op = vecs[i].op; d = vecs[i].d; si = vecs[i].si;
            step();
            check_state($sformatf("vec%0d", i), vecs[i].exp_q, 1'b0, 1'b0);
            check($sformatf("vec%0d.so", i), 32'(so), 32'(vecs[i].exp_so));
        end

        // shlN amt=3 from 0x01; op/d changed while busy must be ignored
        op = 3'b011; d = 8'h01; step();
        op = 3'b110; amt = 4'd3; si = 1'b0; step();
        check_state("shlN.accept", 8'h01, 1'b1, 1'b0);
        op = 3'b011; d = 8'hFF; amt = 4'd0;
        step(); check_state("shlN.s1", 8'h02, 1'b1, 1'b0);
        step(); check_state("shlN.s2", 8'h04, 1'b1, 1'b0);
        step(); check_state("shlN.s3", 8'h08, 1'b1, 1'b0);
        check("shlN.so", 32'(so), 32'd0);
        step(); check_state("shlN.done", 8'h08, 1'b0, 1'b1);
        op = 3'b000;
        step(); check_state("shlN.after", 8'h08, 1'b0, 1'b0);

        // shlN amt=0: one busy cycle, q unchanged, then done
        op = 3'b110; amt = 4'd0; step();
        check_state("amt0.accept", 8'h08, 1'b1, 1'b0);
        op = 3'b000;
        step(); check_state("amt0.done", 8'h08, 1'b0, 1'b1);
        step(); check_state("amt0.after", 8'h08, 1'b0, 1'b0);

        // shrN amt=15 clamps to 8 shifts
        op = 3'b011; d = 8'h00; step();
        op = 3'b101; amt = 4'd15; si = 1'b1; step();
        op = 3'b000;
        for (int i = 0; i < 8; i++) step();
        check_state("clamp.s8", ROT ? 8'h00 : 8'hFF, 1'b1, 1'b0);
        check("clamp.so", 32'(so), 32'd0);
        step(); check_state("clamp.done", ROT ? 8'h00 : 8'hFF, 1'b0, 1'b1);

        // reset aborts shrN mid-sequence with no later done
        op = 3'b011; d = 8'hA5; si = 1'b0; step();
        op = 3'b101; amt = 4'd5; step();
        op = 3'b000;
        step(); step();
        check_state("abort.s2", ROT ? 8'h69 : 8'h29, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check_state("abort.rst", 8'h00, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_state($sformatf("abort.post%0d", i), 8'h00, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
